// File: rtl/gray_sweep_ctrl_pkg.sv
// gray_sweep_ctrl_pkg: shared state encoding, sizing constants and Gray helper for the sweep sequencer
package gray_sweep_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int STEPS = 8;
  localparam int RESULT_W = 16;
  function automatic logic [2:0] gray3(input logic [2:0] k);
    return k ^ (k >> 1);
  endfunction
endpackage

// File: rtl/gray_sweep_ctrl_settle_timer.sv
// settle_timer: counts 0..SETTLE-1 while enabled; ports clk, rst, clear, enable in; expire out (count==SETTLE-1)
module settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [7:0] count;
  assign expire = count == 8'(SETTLE - 1);
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (enable) count <= expire ? 8'd0 : count + 8'd1;
endmodule

// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: sweeps abc through 8 Gray codes, holding each SETTLE cycles and packing sampled {y1,y0} into result; ports clk, rst, start, abort, y1, y0 in; abc, step, busy, done, result out
module gray_sweep_ctrl
  import gray_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                y1,
  input  logic                y0,
  output logic [2:0]          abc,
  output logic [2:0]          step,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result
);
  state_t state, nxt;
  logic [2:0] k_nxt;
  logic [RESULT_W-1:0] res_nxt;
  logic expire;
  // Counter only runs in RUN; abort clears it so a later sweep starts from zero.
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != RUN || abort),
    .enable (state == RUN),
    .expire (expire)
  );
  always_comb begin
    nxt = state;
    k_nxt = step;
    res_nxt = result;
    case (state)
      IDLE: if (start) begin
        nxt = RUN;
        k_nxt = '0;
        res_nxt = '0;
      end
      RUN: if (abort) nxt = IDLE;
      else if (expire) begin
        res_nxt[{step, 1'b0} +: 2] = {y1, y0};
        nxt = step == 3'(STEPS - 1) ? DONE : RUN;
        k_nxt = step + 3'd1;
      end
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next-state decode so they change on the same edge as the state.
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      step <= '0;
      abc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      state <= nxt;
      step <= nxt == RUN ? k_nxt : 3'd0;
      abc <= nxt == RUN ? gray3(k_nxt) : 3'd0;
      busy <= nxt == RUN;
      done <= nxt == DONE;
      result <= res_nxt;
    end
endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// tb_gray_sweep_ctrl: randomized and directed checks of two sweep instances (SETTLE=4 and SETTLE=1) against an elapsed-time model
module tb_gray_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] tbl [8];
  logic [2:0] abc [2];
  logic [2:0] step [2];
  logic busy [2], done [2];
  logic [15:0] result [2];
  logic [1:0] y [2];
  int checks = 0, failures = 0;
  int mode [2], n [2];
  logic [15:0] res [2];
  int sv [2] = '{4, 1};

  always #5 clk = ~clk;
  assign y[0] = tbl[abc[0]];
  assign y[1] = tbl[abc[1]];

  gray_sweep_ctrl #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y1(y[0][1]), .y0(y[0][0]),
    .abc(abc[0]), .step(step[0]), .busy(busy[0]), .done(done[0]), .result(result[0])
  );
  gray_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y1(y[1][1]), .y0(y[1][0]),
    .abc(abc[1]), .step(step[1]), .busy(busy[1]), .done(done[1]), .result(result[1])
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gray(input int k);
    return k ^ (k >> 1);
  endfunction

  // Model tracks cycles elapsed since start; step = elapsed/SETTLE, capture on the last cycle of each window.
  task automatic model_step();
    for (int i = 0; i < 2; i++)
      if (rst) begin
        mode[i] = 0; n[i] = 0; res[i] = 0;
      end else if (mode[i] == 0) begin
        if (start) begin mode[i] = 1; n[i] = 0; res[i] = 0; end
      end else if (mode[i] == 1) begin
        if (abort) mode[i] = 0;
        else begin
          if (n[i] % sv[i] == sv[i] - 1) res[i][2*(n[i]/sv[i]) +: 2] = tbl[gray(n[i]/sv[i])];
          n[i]++;
          if (n[i] == 8 * sv[i]) mode[i] = 2;
        end
      end else mode[i] = 0;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int k;
      k = mode[i] == 1 ? n[i] / sv[i] : 0;
      check($sformatf("busy%0d", i), 16'(busy[i]), 16'(mode[i] == 1));
      check($sformatf("done%0d", i), 16'(done[i]), 16'(mode[i] == 2));
      check($sformatf("step%0d", i), 16'(step[i]), 16'(k));
      check($sformatf("abc%0d", i), 16'(abc[i]), 16'(gray(k)));
      check($sformatf("result%0d", i), result[i], res[i]);
    end
  endtask

  task automatic cyc(input logic s, input logic a, input logic r);
    start = s; abort = a; rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_xor_tbl();
    for (int v = 0; v < 8; v++) tbl[v] = {v[2] ^ v[0], v[1]};
  endtask

  initial begin
    set_xor_tbl();
    for (int i = 0; i < 2; i++) begin mode[i] = 0; n[i] = 0; res[i] = 0; end
    @(negedge clk);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("reset_busy", 16'(busy[0]), 16'd0);
    check("reset_result", result[0], 16'h0000);
    // full sweep on both instances
    cyc(1, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      cyc(0, 0, 0);
      if (i == 8) check("s1_done_t8", 16'(done[1]), 16'd1);
      if (i == 31) check("s4_no_done_t31", 16'(done[0]), 16'd0);
    end
    check("s4_done_t32", 16'(done[0]), 16'd1);
    check("s4_result", result[0], 16'h8778);
    check("s1_result", result[1], 16'h8778);
    repeat (3) cyc(0, 0, 0);
    // abort at step 3, count 2
    cyc(1, 0, 0);
    repeat (14) cyc(0, 0, 0);
    cyc(0, 1, 0);
    check("abort_busy", 16'(busy[0]), 16'd0);
    check("abort_low", 16'(result[0][5:0]), 16'b111000);
    check("abort_high", 16'(result[0][15:6]), 16'd0);
    repeat (4) cyc(0, 0, 0);
    // reset during step 5, then clean sweep
    cyc(1, 0, 0);
    repeat (21) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("rst_mid_result", result[0], 16'h0000);
    check("rst_mid_abc", 16'(abc[0]), 16'd0);
    cyc(1, 0, 0);
    repeat (34) cyc(0, 0, 0);
    check("rst_resweep", result[0], 16'h8778);
    // start held high across sweeps
    repeat (80) cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    // abort coincident with final capture
    cyc(1, 0, 0);
    repeat (31) cyc(0, 0, 0);
    cyc(0, 1, 0);
    check("abort_final_hi", 16'(result[0][15:14]), 16'd0);
    check("abort_final_lo", 16'(result[0][13:0]), 16'h0778);
    check("abort_final_done", 16'(done[0]), 16'd0);
    cyc(0, 0, 0);
    // random traffic with random driven-block truth tables
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 99) == 0)
        for (int v = 0; v < 8; v++) tbl[v] = 2'($urandom);
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 120) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
